div_unit: RTL
=============

# div_unit

Iterative 32-bit integer divider for the execute stage of the 5-stage MIPS pipeline. It serves DIV/DIVU. It accepts a request from the execute-stage control, computes quotient and remainder over 32 cycles, and holds the pipeline stalled while it runs. It returns a 64-bit {remainder, quotient} word that the memory-stage HI/LO write path consumes as {hi, lo}.

## Interface
Parameters:
- none (fixed 32-bit operands; 6-bit internal counter)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  division request; level, held by EX while DIV/DIVU occupies EX
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU
- cancel  in  1  EX flush; abandons any operation in flight
- opdata1  in  32  dividend (rs value after forwarding)
- opdata2  in  32  divisor (rt value after forwarding)
- result  out  64  {remainder[63:32], quotient[31:0]}; registered
- ready  out  1  result valid this cycle; high for exactly one cycle
- stall  out  1  combinational stall request to the hazard unit

## Operation
- States: IDLE, DZERO, ON, END. Reset state is IDLE.
- IDLE:
  - cancel=1: stay in IDLE.
  - start=1 and opdata2==0: go to DZERO.
  - start=1 and opdata2!=0: latch operands, clear counter, go to ON.
- Operand latch (ON entry):
  - When signed_div=1, take |opdata1| and |opdata2|.
  - Record neg_q = sign1 XOR sign2 and neg_r = sign1.
  - When signed_div=0, latch the raw values with neg_q = neg_r = 0.
  - Operand changes after the latch are ignored.
- ON: one restoring step per cycle on a 65-bit working register.
  - Shift left, trial-subtract the divisor from the upper 33 bits, keep the result if it is non-negative, and shift in the quotient bit.
  - Counter increments each step. The step taken with counter==31 is the last one and moves the state to END.
- END:
  - result register holds the final quotient and remainder.
  - Quotient is negated if neg_q; remainder is negated if neg_r.
  - Next edge goes to IDLE.
- DZERO: next edge loads result = {opdata1 latched, 32'hFFFF_FFFF} and goes to END.
- Signed overflow: 0x8000_0000 / 0xFFFF_FFFF gives quotient 0x8000_0000 and remainder 0. This falls out of the 32-bit negate wrap and needs no special case.
- Remainder sign always follows the dividend; |remainder| < |divisor|.
- cancel=1 in any state forces IDLE on the next edge.
  - ready is not asserted for the cancelled operation and result keeps its previous value.
  - cancel has priority over start.
- result holds its value from END until the next END; it is never cleared except by rst.
- stall = (IDLE & start & ~cancel) | ON | DZERO. stall is low in END, so EX advances in the same cycle it samples result.
- ready = (state==END).
- rst asserted in any state: state=IDLE, counter=0, result=0, ready=0, stall=0, asynchronously. Recovery is on the first rising edge after deassertion.

## Timing
- Request first seen with start=1 at cycle T, nonzero divisor:
  - ON for cycles T+1..T+32.
  - END (ready=1) at cycle T+33.
  - stall high for cycles T..T+32 (33 cycles); low at T+33.
- Divisor zero:
  - DZERO at T+1.
  - END at T+2.
  - stall high for T..T+1.
- Back-to-back divides: when start is still high in the cycle after END (the next instruction is a divide), it is sampled in IDLE at T+34 and runs a fresh operation.
- Latency is data-independent; there is no early termination.
- Outputs after reset: result=0, ready=0, stall=0 (stall follows start combinationally once rst is low).

## Test plan
- DIVU 100/7, start at T:
  - stall=1 for T..T+32.
  - ready=1 only at T+33.
  - result = {32'd2, 32'd14}.
- DIV 0xFFFF_FFF9 (−7) / 2:
  - quotient 0xFFFF_FFFD (−3), remainder 0xFFFF_FFFF (−1).
  - The same operands with DIVU give quotient 0x7FFF_FFFC, remainder 1.
- DIV 0x8000_0000 / 0xFFFF_FFFF gives result = {32'h0, 32'h8000_0000}. DIV 7/−2 gives quotient 0xFFFF_FFFD, remainder 1.
- Divide by zero, DIVU 5/0:
  - ready at T+2.
  - result = {32'd5, 32'hFFFF_FFFF}.
  - stall high for exactly 2 cycles.
- Cancel:
  - Start 100/7 at T, pulse cancel at T+10.
  - IDLE at T+11, stall=0, no ready pulse, result unchanged from the previous value.
  - New start 9/3 at T+12 gives ready at T+45 with {0, 3}.
- Reset:
  - Assert rst asynchronously mid-ON (between edges) at T+20.
  - ready, stall and result go to 0 immediately.
  - After release, start 50/5 completes normally in 33 cycles with {0, 10}.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: iterative 32-bit restoring divider for DIV/DIVU in the EX stage.
// Returns {remainder, quotient} after a fixed 32-step run. The pipeline is
// held stalled until the cycle the result is presented.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic        cancel,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  output logic [63:0] result,
  output logic        ready,
  output logic        stall
);

  typedef enum logic [1:0] {S_IDLE, S_DZERO, S_ON, S_END} state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  // {partial remainder, dividend/quotient}. The 65th bit of the working value
  // only exists transiently after the shift, so it is not stored.
  logic [63:0] r_work;
  logic [31:0] r_divisor;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [63:0] r_result;

  logic [31:0] w_op1_abs;
  logic [31:0] w_op2_abs;
  logic [64:0] w_shift;
  logic [32:0] w_diff;
  logic [63:0] w_next;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  // Magnitudes for signed divides; the most negative value maps onto itself,
  // which reads correctly as 2^31 unsigned.
  always_comb begin
    w_op1_abs = (signed_div && opdata1[31]) ? -opdata1 : opdata1;
    w_op2_abs = (signed_div && opdata2[31]) ? -opdata2 : opdata2;
  end

  // One restoring step: shift, trial-subtract from the upper 33 bits, keep the
  // difference when it is non-negative and shift in the quotient bit.
  always_comb begin
    w_shift = {r_work, 1'b0};
    w_diff  = w_shift[64:32] - {1'b0, r_divisor};
    if (w_diff[32]) w_next = w_shift[63:0];
    else            w_next = {w_diff[31:0], w_shift[31:1], 1'b1};
    w_quo = r_neg_q ? -w_next[31:0]  : w_next[31:0];
    w_rem = r_neg_r ? -w_next[63:32] : w_next[63:32];
  end

  // Control FSM and datapath registers; cancel aborts without touching result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 6'd0;
      r_work    <= 64'd0;
      r_divisor <= 32'd0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= 64'd0;
    end else if (cancel) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (opdata2 == 32'd0) begin
              // Keep the raw dividend for the divide-by-zero result.
              r_work  <= {32'd0, opdata1};
              r_state <= S_DZERO;
            end else begin
              r_work    <= {32'd0, w_op1_abs};
              r_divisor <= w_op2_abs;
              r_neg_q   <= signed_div & (opdata1[31] ^ opdata2[31]);
              r_neg_r   <= signed_div & opdata1[31];
              r_cnt     <= 6'd0;
              r_state   <= S_ON;
            end
          end
        end
        S_ON: begin
          r_work <= w_next;
          r_cnt  <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            r_result <= {w_rem, w_quo};
            r_state  <= S_END;
          end
        end
        S_DZERO: begin
          r_result <= {r_work[31:0], 32'hFFFF_FFFF};
          r_state  <= S_END;
        end
        S_END: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign result = r_result;
  assign ready  = (r_state == S_END);
  // Stall is released in END so EX advances in the cycle it samples result.
  assign stall  = ~rst & (((r_state == S_IDLE) & start & ~cancel) |
                          (r_state == S_ON) | (r_state == S_DZERO));

endmodule
